escalonador_sensores: RTL and testbench
=======================================

// Module: escalonador_sensores
// PURPOSE
//  Round-robin poll scheduler that shares one byte-level UART TX/RX pair between N_SENSORS sensors.
//  Each sweep, it sends a 16-bit request to each enabled sensor and waits for a 16-bit reply.
//  It classifies the reply (reading / alarm / error) and publishes results to the Nios-side arbitro logic.
//  It sits between the UART byte modules and the custom-instruction front end.
// PARAMETERS
//  N_SENSORS    4       number of sensor slots; ID_W = clog2(N_SENSORS) (localparam, minimum 1)
//  PERIOD_CYC   500000  cycles between automatic sweep starts
//  TIMEOUT_CYC  50000   cycles allowed for a full 2-byte reply after the request's last byte is accepted
//  REQ_CMD      8'h31   command byte of the request packet
// PORTS
//  clk           in   1          system clock
//  reset         in   1          synchronous, active-high
//  clk_en        in   1          0 freezes every register (FSM, counters, flags)
//  start         in   1          1-cycle pulse; requests an immediate sweep
//  enable_mask   in   N_SENSORS  1 = slot polled; sampled at sweep start only
//  alarm_clr     in   N_SENSORS  per-slot clear for alarm_flags and timeout_flags
//  tx_data       out  8          byte to UART TX
//  tx_start      out  1          1-cycle strobe; issued only when tx_busy = 0
//  tx_busy       in   1          UART TX busy
//  rx_data       in   8          byte from UART RX
//  rx_valid      in   1          1-cycle strobe; rx_data is valid
//  reading_valid out  1          1-cycle pulse; reading_id and reading_data are updated
//  reading_id    out  ID_W       slot of the last good reading
//  reading_data  out  8          data byte of the last good reading
//  alarm_flags   out  N_SENSORS  sticky; set by an alarm reply
//  timeout_flags out  N_SENSORS  sticky; set by a timeout or a bad command byte
//  busy          out  1          1 while a sweep is in progress
//  state         out  4          FSM state encoding, for debug and bench
// BEHAVIOUR
//  - Reset: every output is 0; FSM = IDLE (4'h0); period counter = PERIOD_CYC-1; slot = 0.
//  - Packet format: [15:8] cmd, [7:0] data; high byte on the wire first.
//    Request = {REQ_CMD, 6'b0, slot}.
//  - Reply commands: 8'h32 = reading; 8'h37 = alarm; any other value = error.
//  - Period counter runs in every state.
//    At 0 it reloads and raises a sweep request.
//    A sweep request (period or start) arriving during a sweep is held (1-deep) and runs after DONE.
//  - FSM states:
//    IDLE(0): on a pending request, latch mask := enable_mask.
//      mask == 0: drop the request and stay in IDLE.
//      mask != 0: slot := lowest set bit; go to TX_HI.
//    TX_HI(1): wait for tx_busy = 0; pulse tx_start with REQ_CMD; go to TX_LO.
//    TX_LO(2): wait for tx_busy = 0; pulse tx_start with the id byte; load the timeout counter; go to RX_HI.
//    RX_HI(3): on rx_valid, capture cmd; go to RX_LO.
//    RX_LO(4): on rx_valid, capture data; go to EVAL. The timeout counter is not reloaded between bytes.
//    EVAL(5): takes 1 cycle. Classifies the reply:
//      cmd 0x32: reading_valid = 1, reading_id = slot, reading_data = data.
//      cmd 0x37: alarm_flags[slot] := 1; reading_valid stays 0.
//      otherwise: timeout_flags[slot] := 1.
//      Then go to NEXT.
//    NEXT(6): clear the served bit in the latched mask.
//      Remaining bits: slot := next set bit above the current slot; go to TX_HI.
//      No bits left: go to DONE.
//    DONE(7): busy = 0 for this cycle; go to IDLE.
//  - Timeout: if the counter reaches 0 in RX_HI or RX_LO:
//    timeout_flags[slot] := 1; any partial byte is discarded; go to NEXT.
//    rx_valid on the same cycle as expiry is ignored.
//  - rx_valid outside RX_HI/RX_LO is discarded.
//  - busy = 1 in states 1..6.
//  - In the same cycle, a set beats alarm_clr for the same slot.
//  - reset asserted mid-sweep: return to the reset state on the next edge.
//    A partial packet is abandoned and tx_start is not re-issued.
// CONFIGURATION
//  ESCALONADOR_RETRY_EN
//    Defined: on the first timeout for a slot in a sweep, return to TX_HI for the same slot (one retry).
//      Only a second timeout sets timeout_flags.
//      Error replies are not retried.
//    Undefined: a timeout goes straight to NEXT, as described above.
// TESTING
//  T1 mask=4'b0101, start; sensor 0 replies 32 05, sensor 2 replies 32 1A:
//     TX bytes 31 00 31 02; two reading_valid pulses, (0,0x05) then (2,0x1A); busy falls.
//  T2 mask=4'b0010; sensor 1 replies 37 00:
//     alarm_flags = 4'b0010, no reading_valid; alarm_clr[1] -> flags = 0.
//  T3 mask=4'b0001, no reply:
//     timeout_flags[0] set exactly TIMEOUT_CYC cycles after the 2nd tx_start.
//     With ESCALONADOR_RETRY_EN: the request is resent once first, and the flag is set after 2*TIMEOUT_CYC.
//  T4 reply 41 09:
//     timeout_flags[slot] set, no retry, FSM proceeds to the next slot.
//  T5 random rx_valid noise in IDLE, then start mid-sweep:
//     noise ignored; the held start runs a second sweep after DONE; mask=0 -> stays in IDLE.
//  T6 reset pulsed in RX_LO:
//     next cycle all outputs are 0 and state = 4'h0; no further tx_start until a new request.

Source files
------------

// File: rtl/escalonador_sensores.sv
// Round-robin poll scheduler sharing one UART TX/RX byte pair between N_SENSORS sensors.
// Optional feature macro ESCALONADOR_RETRY_EN: one request retry per slot on a reply timeout.

module escalonador_sensores #(
  parameter int unsigned  N_SENSORS   = 4,
  parameter int unsigned  PERIOD_CYC  = 500000,
  parameter int unsigned  TIMEOUT_CYC = 50000,
  parameter logic [7:0]   REQ_CMD     = 8'h31,
  localparam int unsigned ID_W        = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 start,
  input  logic [N_SENSORS-1:0] enable_mask,
  input  logic [N_SENSORS-1:0] alarm_clr,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 reading_valid,
  output logic [ID_W-1:0]      reading_id,
  output logic [7:0]           reading_data,
  output logic [N_SENSORS-1:0] alarm_flags,
  output logic [N_SENSORS-1:0] timeout_flags,
  output logic                 busy,
  output logic [3:0]           state
);

  localparam int unsigned PER_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [7:0]  CmdReading = 8'h32;
  localparam logic [7:0]  CmdAlarm   = 8'h37;

  typedef enum logic [3:0] {
    StIdle = 4'h0,
    StTxHi = 4'h1,
    StTxLo = 4'h2,
    StRxHi = 4'h3,
    StRxLo = 4'h4,
    StEval = 4'h5,
    StNext = 4'h6,
    StDone = 4'h7
  } state_e;

  state_e               st_q, st_d;
  logic [PER_W-1:0]     per_q, per_d;
  logic                 pend_q, pend_d;
  logic [N_SENSORS-1:0] mask_q, mask_d;
  logic [ID_W-1:0]      slot_q, slot_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [7:0]           data_q, data_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [ID_W-1:0]      rd_id_q, rd_id_d;
  logic [7:0]           rd_data_q, rd_data_d;
  logic [N_SENSORS-1:0] alarm_q, alarm_d;
  logic [N_SENSORS-1:0] tmo_q, tmo_d;
  logic                 busy_q, busy_d;
`ifdef ESCALONADOR_RETRY_EN
  logic                 retry_q, retry_d;
`endif

  logic                 tick;
  logic                 req_in;
  logic                 expired;
  logic [N_SENSORS-1:0] slot_oh;
  logic [N_SENSORS-1:0] mask_left;
  logic [N_SENSORS-1:0] alarm_set;
  logic [N_SENSORS-1:0] tmo_set;

  // Served bits are cleared as the sweep advances, so the lowest remaining bit is the next slot.
  function automatic logic [ID_W-1:0] lowest_set(input logic [N_SENSORS-1:0] m);
    lowest_set = '0;
    for (int i = N_SENSORS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = ID_W'(i);
    end
  endfunction

  always_comb begin
    st_d       = st_q;
    per_d      = per_q;
    mask_d     = mask_q;
    slot_d     = slot_q;
    to_d       = to_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    rd_valid_d = 1'b0;
    rd_id_d    = rd_id_q;
    rd_data_d  = rd_data_q;
    alarm_set  = '0;
    tmo_set    = '0;
    expired    = 1'b0;
    slot_oh    = N_SENSORS'(1) << slot_q;
    mask_left  = mask_q & ~slot_oh;
`ifdef ESCALONADOR_RETRY_EN
    retry_d    = retry_q;
`endif

    tick = 1'b0;
    if (per_q == '0) begin
      per_d = PER_W'(PERIOD_CYC - 1);
      tick  = 1'b1;
    end else begin
      per_d = per_q - 1'b1;
    end
    req_in = tick | start;
    pend_d = pend_q | req_in;

    if ((st_q == StRxHi || st_q == StRxLo) && to_q != '0) begin
      to_d = to_q - 1'b1;
    end

    unique case (st_q)
      StIdle: begin
        if (pend_q) begin
          pend_d = req_in;
          mask_d = enable_mask;
          if (enable_mask != '0) begin
            slot_d = lowest_set(enable_mask);
            st_d   = StTxHi;
`ifdef ESCALONADOR_RETRY_EN
            retry_d = 1'b0;
`endif
          end
        end
      end
      // tx_start_q gates the wait so a byte is never issued before the UART reflects the last one.
      StTxHi: begin
        if (!tx_busy && !tx_start_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = REQ_CMD;
          st_d       = StTxLo;
        end
      end
      StTxLo: begin
        if (!tx_busy && !tx_start_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = 8'(slot_q);
          to_d       = TO_W'(TIMEOUT_CYC - 1);
          st_d       = StRxHi;
        end
      end
      StRxHi: begin
        if (to_q == '0) begin
          expired = 1'b1;
        end else if (rx_valid) begin
          cmd_d = rx_data;
          st_d  = StRxLo;
        end
      end
      StRxLo: begin
        if (to_q == '0) begin
          expired = 1'b1;
        end else if (rx_valid) begin
          data_d = rx_data;
          st_d   = StEval;
        end
      end
      StEval: begin
        if (cmd_q == CmdReading) begin
          rd_valid_d = 1'b1;
          rd_id_d    = slot_q;
          rd_data_d  = data_q;
        end else if (cmd_q == CmdAlarm) begin
          alarm_set = slot_oh;
        end else begin
          tmo_set = slot_oh;
        end
        st_d = StNext;
      end
      StNext: begin
        mask_d = mask_left;
        if (mask_left != '0) begin
          slot_d = lowest_set(mask_left);
          st_d   = StTxHi;
`ifdef ESCALONADOR_RETRY_EN
          retry_d = 1'b0;
`endif
        end else begin
          st_d = StDone;
        end
      end
      StDone: st_d = StIdle;
      default: st_d = StIdle;
    endcase

    if (expired) begin
`ifdef ESCALONADOR_RETRY_EN
      if (!retry_q) begin
        retry_d = 1'b1;
        st_d    = StTxHi;
      end else begin
        tmo_set = slot_oh;
        st_d    = StNext;
      end
`else
      tmo_set = slot_oh;
      st_d    = StNext;
`endif
    end

    // A set in the same cycle wins over the clear for that slot.
    alarm_d = (alarm_q & ~alarm_clr) | alarm_set;
    tmo_d   = (tmo_q & ~alarm_clr) | tmo_set;
    busy_d  = (st_d != StIdle) && (st_d != StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= StIdle;
      per_q      <= PER_W'(PERIOD_CYC - 1);
      pend_q     <= 1'b0;
      mask_q     <= '0;
      slot_q     <= '0;
      to_q       <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
      rd_data_q  <= '0;
      alarm_q    <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
`ifdef ESCALONADOR_RETRY_EN
      retry_q    <= 1'b0;
`endif
    end else if (clk_en) begin
      st_q       <= st_d;
      per_q      <= per_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      slot_q     <= slot_d;
      to_q       <= to_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
      rd_data_q  <= rd_data_d;
      alarm_q    <= alarm_d;
      tmo_q      <= tmo_d;
      busy_q     <= busy_d;
`ifdef ESCALONADOR_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_start      = tx_start_q;
  assign reading_valid = rd_valid_q;
  assign reading_id    = rd_id_q;
  assign reading_data  = rd_data_q;
  assign alarm_flags   = alarm_q;
  assign timeout_flags = tmo_q;
  assign busy          = busy_q;
  assign state         = st_q;

endmodule

// File: tb/tb_escalonador_sensores.sv
// Scoreboard bench for escalonador_sensores: reactive UART/sensor model, queued expectations,
// decoupled monitor, directed cases plus randomized sweeps.

module tb_escalonador_sensores;

  localparam int unsigned PER = 3000;
  localparam int unsigned TO  = 60;
  localparam logic [7:0]  REQ = 8'h31;
  localparam int KREAD = 0, KALARM = 1, KERR = 2, KNONE = 3, KPART = 4;

  logic       clk = 1'b0;
  logic       reset, clk_en, start;
  logic [3:0] enable_mask, alarm_clr;
  logic [7:0] tx_data;
  logic       tx_start, tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       reading_valid;
  logic [1:0] reading_id;
  logic [7:0] reading_data;
  logic [3:0] alarm_flags, timeout_flags;
  logic       busy;
  logic [3:0] state;

  escalonador_sensores #(
    .N_SENSORS  (4),
    .PERIOD_CYC (PER),
    .TIMEOUT_CYC(TO),
    .REQ_CMD    (REQ)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .start        (start),
    .enable_mask  (enable_mask),
    .alarm_clr    (alarm_clr),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .reading_valid(reading_valid),
    .reading_id   (reading_id),
    .reading_data (reading_data),
    .alarm_flags  (alarm_flags),
    .timeout_flags(timeout_flags),
    .busy         (busy),
    .state        (state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int         kind [4];
  logic [7:0] rcmd [4];
  logic [7:0] rdata[4];
  bit         noise_en = 1'b0;

  logic [7:0] exp_tx[$];
  logic [9:0] exp_rd[$];
  logic [3:0] m_alarm = 4'h0;
  logic [3:0] m_to    = 4'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sensor/UART model: drives #1 after negedge so the monitor sees the values the DUT used.
  initial begin
    int busy_cnt, txcnt, gap, s;
    logic [7:0] q[$];
    busy_cnt = 0; txcnt = 0; gap = 0;
    tx_busy = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      rx_valid = 1'b0;
      if (reset) begin
        txcnt = 0; busy_cnt = 0; q.delete();
      end else begin
        if (tx_start) begin
          busy_cnt = $urandom_range(1, 4);
          txcnt++;
          if (txcnt == 2) begin
            txcnt = 0;
            s = int'(tx_data[1:0]);
            case (kind[s])
              KREAD:  begin q.push_back(8'h32); q.push_back(rdata[s]); end
              KALARM: begin q.push_back(8'h37); q.push_back(rdata[s]); end
              KERR:   begin q.push_back(rcmd[s]); q.push_back(rdata[s]); end
              KPART:  q.push_back(rcmd[s]);
              default: ;
            endcase
            gap = $urandom_range(1, 8);
          end
        end else if (busy_cnt > 0) begin
          busy_cnt--;
        end
        if (q.size() > 0) begin
          if (gap == 0) begin
            rx_valid = 1'b1;
            rx_data  = q.pop_front();
            gap      = $urandom_range(0, 4);
          end else begin
            gap--;
          end
        end else if (noise_en) begin
          rx_valid = ($urandom_range(0, 2) == 0);
          rx_data  = 8'($urandom);
        end
      end
      tx_busy = (busy_cnt > 0);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a TX byte or a reading.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx_start) begin
        check("tx_start_while_busy", tx_busy, 0);
        if (exp_tx.size() == 0) check("unexpected_tx", tx_data, 'hdead);
        else check("tx_byte", tx_data, exp_tx.pop_front());
      end
      if (!reset && reading_valid) begin
        if (exp_rd.size() == 0) check("unexpected_reading", {reading_id, reading_data}, 'hdead);
        else check("reading", {reading_id, reading_data}, exp_rd.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [3:0] mask, input int reps);
    int att;
    for (int r = 0; r < reps; r++) begin
      for (int s = 0; s < 4; s++) begin
        if (mask[s]) begin
          att = 1;
`ifdef ESCALONADOR_RETRY_EN
          if (kind[s] == KNONE || kind[s] == KPART) att = 2;
`endif
          for (int a = 0; a < att; a++) begin
            exp_tx.push_back(REQ);
            exp_tx.push_back(8'(s));
          end
          case (kind[s])
            KREAD:   exp_rd.push_back({2'(s), rdata[s]});
            KALARM:  m_alarm[s] = 1'b1;
            default: m_to[s] = 1'b1;
          endcase
        end
      end
    end
  endtask

  task automatic wait_busy(input logic val, input int limit, input logic [3:0] clr_eval,
                           input string name);
    int n = 0;
    while (busy !== val && n < limit) begin
      @(negedge clk);
      alarm_clr = (state == 4'h5) ? clr_eval : 4'h0;
      n++;
    end
    alarm_clr = 4'h0;
    check(name, busy, val);
  endtask

  task automatic check_flags(input string name);
    check({name, "_alarm"}, alarm_flags, m_alarm);
    check({name, "_timeout"}, timeout_flags, m_to);
  endtask

  task automatic clear_flags(input logic [3:0] c);
    @(negedge clk); alarm_clr = c;
    @(negedge clk); alarm_clr = 4'h0;
    m_alarm &= ~c;
    m_to    &= ~c;
    check_flags("after_clear");
  endtask

  task automatic run_sweep(input logic [3:0] mask, input bit twice, input logic [3:0] clr_eval);
    push_exp(mask, twice ? 2 : 1);
    @(negedge clk); enable_mask = mask; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_busy(1'b1, 20, 4'h0, "sweep_start");
    if (twice) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_busy(1'b0, 2000, 4'h0, "first_sweep_end");
      wait_busy(1'b1, 20, 4'h0, "held_sweep_start");
    end
    enable_mask = 4'h0;
    wait_busy(1'b0, 2000, clr_eval, "sweep_end");
    repeat (3) @(negedge clk);
    check("tx_drained", exp_tx.size(), 0);
    check("reading_drained", exp_rd.size(), 0);
    check("idle_after_sweep", state, 4'h0);
    check_flags("sweep");
  endtask

  task automatic timeout_test(input int s, input int freeze);
    int seen = 0;
    int n = 0;
    int cnt = 0;
    kind[s] = KNONE;
    push_exp(4'(1 << s), 1);
    @(negedge clk); enable_mask = 4'(1 << s); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (seen < 2 && n < 200) begin
      @(negedge clk);
      if (busy) enable_mask = 4'h0;
      if (tx_start) seen++;
      n++;
    end
    check("request_sent", seen, 2);
    while (!timeout_flags[s] && cnt < 4 * TO + freeze + 50) begin
      @(negedge clk);
      cnt++;
      clk_en = !(cnt >= 5 && cnt < 5 + freeze);
    end
    clk_en = 1'b1;
`ifdef ESCALONADOR_RETRY_EN
    check("timeout_after_retry", cnt >= 2 * TO + freeze, 1);
`else
    check("timeout_latency", cnt, TO + freeze);
`endif
    wait_busy(1'b0, 500, 4'h0, "timeout_sweep_end");
    repeat (2) @(negedge clk);
    check("tx_drained_to", exp_tx.size(), 0);
    check_flags("timeout");
    clear_flags(4'(1 << s));
  endtask

  initial begin
    int nz, ntx, n;
    logic [3:0] m;
    reset = 1'b1; clk_en = 1'b1; start = 1'b0; enable_mask = 4'h0; alarm_clr = 4'h0;
    for (int i = 0; i < 4; i++) begin kind[i] = KREAD; rcmd[i] = 8'h32; rdata[i] = 8'h00; end
    repeat (3) @(negedge clk);
    check("reset_outs_a", {tx_data, tx_start, reading_valid, reading_id, reading_data}, 0);
    check("reset_outs_b", {alarm_flags, timeout_flags, busy, state}, 0);
    reset = 1'b0;

    // T1: two readings in slot order
    rdata[0] = 8'h05; rdata[2] = 8'h1A;
    run_sweep(4'b0101, 1'b0, 4'h0);

    // T2: alarm reply, then clear
    kind[1] = KALARM; rdata[1] = 8'h00;
    run_sweep(4'b0010, 1'b0, 4'h0);
    clear_flags(4'b0010);

    // T3: no reply, exact latency; then the same with a clk_en freeze
    timeout_test(0, 0);
    timeout_test(3, 17);

    // T4: error reply, sweep proceeds to the next slot
    kind[1] = KERR; rcmd[1] = 8'h41; rdata[1] = 8'h09;
    kind[2] = KREAD; rdata[2] = 8'h77;
    run_sweep(4'b0110, 1'b0, 4'h0);
    clear_flags(4'hF);

    // Alarm set during EVAL beats a simultaneous clear
    kind[1] = KALARM; rdata[1] = 8'h55;
    run_sweep(4'b0010, 1'b0, 4'b0010);
    clear_flags(4'b0010);

    // T5: noise in IDLE with an empty mask, then a held start mid-sweep
    noise_en = 1'b1; nz = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start = (i == 100);
      if (state != 4'h0 || busy) nz++;
    end
    start = 1'b0; noise_en = 1'b0;
    repeat (8) @(negedge clk);
    check("noise_idle_cycles", nz, 0);
    check("noise_state", state, 4'h0);
    kind[0] = KREAD; rdata[0] = 8'hC3;
    run_sweep(4'b0001, 1'b1, 4'h0);

    // Randomized sweeps
    for (int it = 0; it < 25; it++) begin
      for (int s = 0; s < 4; s++) begin
        n = $urandom_range(0, 9);
        kind[s]  = (n <= 4) ? KREAD : (n <= 6) ? KALARM : (n == 7) ? KERR : (n == 8) ? KNONE : KPART;
        rdata[s] = 8'($urandom);
        rcmd[s]  = 8'($urandom);
        while (rcmd[s] == 8'h32 || rcmd[s] == 8'h37) rcmd[s] = 8'($urandom);
      end
      m = 4'($urandom_range(1, 15));
      run_sweep(m, ($urandom_range(0, 4) == 0), 4'h0);
      clear_flags(4'($urandom_range(0, 15)));
    end

    // T6: reset in RX_LO abandons the packet
    kind[2] = KPART; rcmd[2] = 8'h32;
    push_exp(4'b0100, 1);
    @(negedge clk); enable_mask = 4'b0100; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (state !== 4'h4 && n < 300) begin
      @(negedge clk);
      if (busy) enable_mask = 4'h0;
      n++;
    end
    check("reached_rx_lo", state, 4'h4);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outs_a", {tx_data, tx_start, reading_valid, reading_id, reading_data}, 0);
    check("midreset_outs_b", {alarm_flags, timeout_flags, busy, state}, 0);
    reset = 1'b0;
    m_alarm = 4'h0; m_to = 4'h0;
    ntx = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx_start) ntx++;
    end
    check("no_tx_after_reset", ntx, 0);
    check("idle_after_reset", state, 4'h0);
    check_flags("post_reset");
    exp_tx.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
